spi_a2d_resp: RTL and testbench
===============================

# spi_a2d_resp

Synthesizable SPI responder that models the 8-channel, 12-bit A2D converter on the far end of the A2D interface's SS_n/SCLK/MOSI/MISO bus. The block decodes the 16-bit channel command in one transaction and returns that channel's 12-bit value in the next transaction. Load-cell, steering-pot and battery values come in on ports, so the full-chip bench and FPGA loopback builds run without an external converter.

## Interface
- Parameters:
  - FRAME_BITS, 16, bits per transaction; any other count is a framing error.
- Ports:
  - clk  in  1  system clock.
  - rst_n  in  1  asynchronous active-low reset.
  - SS_n  in  1  slave select from the master; asynchronous to clk.
  - SCLK  in  1  serial clock from the master, mode 0 (idle low); asynchronous to clk.
  - MOSI  in  1  command data, MSB first.
  - MISO  out  1  response data, MSB first.
  - lft_ld  in  12  value returned for channel 0.
  - rght_ld  in  12  value returned for channel 4.
  - steer_pot  in  12  value returned for channel 5.
  - batt  in  12  value returned for channel 6.
  - cmd_vld  out  1  one-clk pulse when a valid command frame is accepted.
  - cmd_ch  out  3  channel of the last accepted command.
  - frm_err  out  1  one-clk pulse when a frame is rejected.

## Operation
- Input synchronization:
  - SS_n, SCLK and MOSI are each double-flopped into clk.
  - A third flop on SS_n and SCLK provides edge detection: `sclk_rise`, `sclk_fall`, `ss_fall`, `ss_rise`.
- States are IDLE and SHIFT.
- IDLE → SHIFT on `ss_fall`:
  - `tx_shft` loads `{4'h0, resp_val}`.
  - `bit_cnt` clears to 0.
  - MISO is driven from `tx_shft[15]`.
- In SHIFT:
  - `sclk_rise`: shift the synchronized MOSI into `rx_shft` (left shift, LSB in) and increment `bit_cnt` (5-bit counter, saturates at 31).
  - `sclk_fall`: left-shift `tx_shft` with 0 fill.
  - MISO always equals `tx_shft[15]`.
- SHIFT → IDLE on `ss_rise`. The frame is accepted only when both hold:
  - `bit_cnt == FRAME_BITS`, and
  - `rx_shft[15:14] == 2'b00` and `rx_shft[10:0] == 0`.
- On an accepted frame:
  - `cmd_ch <= rx_shft[13:11]`.
  - `resp_val` captures the selected channel input on that same clk: ch0 `lft_ld`, ch4 `rght_ld`, ch5 `steer_pot`, ch6 `batt`, all other channels 12'h000.
  - `cmd_vld` pulses.
- On a rejected frame: `cmd_ch` and `resp_val` are unchanged, and `frm_err` pulses.
- Simultaneous events:
  - `ss_rise` and `sclk_rise` in the same clk: the edge is shifted and counted first, then the frame is evaluated.
  - `ss_fall` while already in SHIFT cannot occur, because SS_n is a single synchronized level.
- An SCLK edge in IDLE is ignored.
- Reset mid-frame returns to IDLE with all reset values. The master's next frame is treated as a fresh first frame.

## Timing
- Reset values:
  - MISO 0, `cmd_vld` 0, `frm_err` 0, `cmd_ch` 3'b000.
  - `resp_val` 12'h000, `tx_shft` 0, `rx_shft` 0, `bit_cnt` 0, state IDLE.
  - All synchronizer flops: SS_n and its edge-detect flop 1, SCLK 0, MOSI 0.
- Edge detection latency is 3 clk from the pin edge.
- MISO changes 3 clk after a SCLK fall, or 3 clk after the SS_n fall for bit 15.
- Supported master timing, which the A2D interface meets:
  - SCLK high and low phases ≥ 4 clk.
  - SS_n fall to the first SCLK rise ≥ 4 clk.
  - Last SCLK fall to SS_n rise ≥ 4 clk.
- `cmd_vld` / `frm_err` assert 4 clk after the SS_n rise (3 sync + 1 register).
- The response to a command is always delivered in the next transaction. The first transaction after reset returns 16'h0000.

## Structure
- Package `a2d_pkg` holds:
  - FRAME_BITS default.
  - Channel constants CH_LFT_LD=0, CH_RGHT_LD=4, CH_STEER=5, CH_BATT=6.
  - State enum `a2d_state_t` {IDLE, SHIFT}.
- Sub-module `sync_edge` (double-flop synchronizer plus rise/fall detect, with a reset-value parameter) is instantiated for SS_n and SCLK. MOSI uses the synchronizer only.

## Test plan
- Reset, then one frame with command 16'h0000 (ch0), `lft_ld`=12'hABC → MISO reads 16'h0000, `cmd_vld` pulses, `cmd_ch`=0. The next frame returns 16'h0ABC.
- Command ch6 with `batt`=12'h7FF, then `batt` changed to 12'h123 before the second frame → second frame returns 16'h07FF (value captured at SS_n rise).
- Command ch2 (16'h1000) → next frame returns 16'h0000. Command ch5 with `steer_pot`=12'hFFF → next frame returns 16'h0FFF.
- 12-bit frame, then a 16-bit frame with `rx_shft`[15:14]=2'b11 → `frm_err` pulses each time, `cmd_ch` and the response are unchanged from the prior valid command.
- Reset asserted after 7 SCLK cycles of a frame → MISO=0 and state IDLE immediately. The next full frame returns 16'h0000.
- Back-to-back frames with the minimum 4-clk phases via the real A2D interface, master cycling channels 0,4,5,6 → every `lft_ld`/`rght_ld`/`steer_pot`/`batt` reading in the master matches its driven input.

Source files
------------

// File: rtl/a2d_pkg.sv
// ---------------------------------------------------------------------------
// a2d_pkg
// Shared definitions for the SPI A2D responder: default frame length, the
// channel numbers that carry live data, the responder state type and the
// command-word format check.
// ---------------------------------------------------------------------------
package a2d_pkg;

    // Bits per SPI transaction; any other count is a framing error.
    localparam int FRAME_BITS_DEF = 16;

    // Channels that return a port value; every other channel reads as zero.
    localparam logic [2:0] CH_LFT_LD  = 3'd0;
    localparam logic [2:0] CH_RGHT_LD = 3'd4;
    localparam logic [2:0] CH_STEER   = 3'd5;
    localparam logic [2:0] CH_BATT    = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } a2d_state_t;

    // A command word is {2'b00, ch[2:0], 11'h000}; anything else is rejected.
    function automatic logic cmd_fmt_ok(input logic [15:0] cmd);
        return (cmd[15:14] == 2'b00) && (cmd[10:0] == 11'h000);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Double-flop synchronizer for an asynchronous level, followed by a third
// flop used purely for edge detection. All three flops reset to RST_VAL so
// that no spurious edge is reported when reset is released.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   asynchronous input level
//   rise      out  one-clk pulse on a synchronized 0->1 transition
//   fall      out  one-clk pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta_ff;
    logic sync_ff;
    logic edge_ff;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_ff <= RST_VAL;
            sync_ff <= RST_VAL;
            edge_ff <= RST_VAL;
        end else begin
            meta_ff <= async_in;
            sync_ff <= meta_ff;
            edge_ff <= sync_ff;
        end
    end

    assign rise =  sync_ff & ~edge_ff;
    assign fall = ~sync_ff &  edge_ff;

endmodule

// File: rtl/spi_a2d_resp.sv
// ---------------------------------------------------------------------------
// spi_a2d_resp
// SPI (mode 0) responder modelling an 8-channel 12-bit A2D converter. A
// 16-bit command frame selects a channel; the selected value is captured when
// the frame closes and is shifted back, MSB first, in the next transaction.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   SS_n       in   slave select (async to clk)
//   SCLK       in   serial clock, idle low (async to clk)
//   MOSI       in   command data, MSB first
//   MISO       out  response data, MSB first
//   lft_ld     in   [11:0] channel 0 value
//   rght_ld    in   [11:0] channel 4 value
//   steer_pot  in   [11:0] channel 5 value
//   batt       in   [11:0] channel 6 value
//   cmd_vld    out  one-clk pulse when a command frame is accepted
//   cmd_ch     out  [2:0] channel of the last accepted command
//   frm_err    out  one-clk pulse when a frame is rejected
// ---------------------------------------------------------------------------
module spi_a2d_resp
    import a2d_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic [11:0] steer_pot,
    input  logic [11:0] batt,
    output logic        cmd_vld,
    output logic [2:0]  cmd_ch,
    output logic        frm_err
);

    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    // -----------------------------------------------------------------------
    // Input synchronization and edge detection
    // -----------------------------------------------------------------------
    logic ss_rise;
    logic ss_fall;
    logic sclk_rise;
    logic sclk_fall;

    sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SS_n),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SCLK),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // MOSI only needs a clean level, sampled on sclk_rise.
    logic mosi_meta;
    logic mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Frame state, shift registers and bit counter
    // -----------------------------------------------------------------------
    a2d_state_t  state;
    logic [15:0] tx_shft;
    logic [15:0] rx_shft;
    logic [4:0]  bit_cnt;
    logic [11:0] resp_val;
    logic        eval_pend;   // frame closed last clk; judge it now

    // The frame is judged one clk after ss_rise. That clk lets a coincident
    // sclk_rise land in rx_shft/bit_cnt before they are inspected, and it
    // places cmd_vld/frm_err four clks after the SS_n pin edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_shft   <= '0;
            rx_shft   <= '0;
            bit_cnt   <= '0;
            eval_pend <= 1'b0;
        end else begin
            eval_pend <= 1'b0;
            case (state)
                IDLE: begin
                    // SCLK edges are ignored until the master selects us.
                    if (ss_fall) begin
                        state   <= SHIFT;
                        tx_shft <= {4'h0, resp_val};
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shft <= {rx_shft[14:0], mosi_sync};
                        // Saturate so an overlong frame can never wrap back
                        // onto a legal count.
                        if (bit_cnt != 5'h1F) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_shft <= {tx_shft[14:0], 1'b0};
                    end
                    if (ss_rise) begin
                        state     <= IDLE;
                        eval_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign MISO = tx_shft[15];

    // -----------------------------------------------------------------------
    // Channel select and command acceptance
    // -----------------------------------------------------------------------
    logic [11:0] sel_val;
    logic        frame_ok;

    // NOTE: every path through a combinational block must assign its outputs;
    // the leading default is what keeps this mux from inferring a latch.
    always_comb begin
        sel_val = 12'h000;
        case (rx_shft[13:11])
            CH_LFT_LD:  sel_val = lft_ld;
            CH_RGHT_LD: sel_val = rght_ld;
            CH_STEER:   sel_val = steer_pot;
            CH_BATT:    sel_val = batt;
            default:    sel_val = 12'h000;
        endcase
    end

    assign frame_ok = (bit_cnt == FRAME_CNT) && cmd_fmt_ok(rx_shft);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_val <= 12'h000;
            cmd_ch   <= 3'b000;
            cmd_vld  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            cmd_vld <= 1'b0;
            frm_err <= 1'b0;
            if (eval_pend) begin
                if (frame_ok) begin
                    cmd_ch   <= rx_shft[13:11];
                    resp_val <= sel_val;
                    cmd_vld  <= 1'b1;
                end else begin
                    // Rejected frames leave the previous command's result
                    // in place for the next transaction.
                    frm_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_a2d_resp.sv
// ---------------------------------------------------------------------------
// tb_spi_a2d_resp
// Self-checking bench for spi_a2d_resp. A bench-side SPI master drives
// SS_n/SCLK/MOSI on clk falling edges and samples MISO at each SCLK rise.
// A transaction-level model tracks the last accepted channel and its captured
// value and predicts the MISO word, the result pulses and cmd_ch.
// ---------------------------------------------------------------------------
module tb_spi_a2d_resp;
    import a2d_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] lft_ld = 12'h000;
    logic [11:0] rght_ld = 12'h000;
    logic [11:0] steer_pot = 12'h000;
    logic [11:0] batt = 12'h000;
    logic        cmd_vld;
    logic [2:0]  cmd_ch;
    logic        frm_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the value the converter will return next, and the
    // channel of the last accepted command.
    logic [11:0] m_resp = 12'h000;
    logic [2:0]  m_ch   = 3'd0;

    spi_a2d_resp #(.FRAME_BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .cmd_vld   (cmd_vld),
        .cmd_ch    (cmd_ch),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [11:0] chan_value(input logic [2:0] ch);
        case (ch)
            3'd0:    return lft_ld;
            3'd4:    return rght_ld;
            3'd5:    return steer_pot;
            3'd6:    return batt;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [15:0] cmd_word(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    task automatic randomize_inputs();
        lft_ld    = 12'($urandom);
        rght_ld   = 12'($urandom);
        steer_pot = 12'($urandom);
        batt      = 12'($urandom);
    endtask

    // One master transaction. joint_end raises SS_n together with the last
    // SCLK rise so both edges are seen by the responder in the same clk.
    task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits,
                             input int ph_lo, input int ph_hi, input bit joint_end);
        logic [15:0] got;
        logic [15:0] exp_word;
        logic [15:0] mask;
        logic        extra;
        bit          valid;
        int          cnt_vld, cnt_err, lat_vld, lat_err;

        got      = '0;
        extra    = 1'b0;
        exp_word = {4'h0, m_resp};

        @(negedge clk);
        SS_n = 1'b0;
        MOSI = cmd[15];
        wait_clks($urandom_range(ph_lo, ph_hi));
        for (int i = 0; i < nbits; i++) begin
            if (joint_end && i == nbits - 1) SS_n = 1'b1;
            SCLK = 1'b1;
            if (i < 16) got[15-i] = MISO;
            else        extra = extra | MISO;
            if (joint_end && i == nbits - 1) break;
            wait_clks($urandom_range(ph_lo, ph_hi));
            SCLK = 1'b0;
            if (i + 1 < 16) MOSI = cmd[14-i];
            else            MOSI = 1'($urandom_range(0, 1));
            wait_clks($urandom_range(ph_lo, ph_hi));
        end
        if (!joint_end) SS_n = 1'b1;

        // Model: the command is judged at the SS_n rise, against the inputs
        // present at that moment.
        valid = (nbits == 16) && (cmd[15:14] == 2'b00) && (cmd[10:0] == 11'h000);
        if (valid) begin
            m_ch   = cmd[13:11];
            m_resp = chan_value(m_ch);
        end

        cnt_vld = 0; cnt_err = 0; lat_vld = 0; lat_err = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (cmd_vld === 1'b1) begin
                cnt_vld++;
                if (lat_vld == 0) lat_vld = k;
            end
            if (frm_err === 1'b1) begin
                cnt_err++;
                if (lat_err == 0) lat_err = k;
            end
        end
        if (joint_end) begin
            SCLK = 1'b0;   // edge while deselected: must be ignored
            wait_clks(4);
        end

        mask = (nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> nbits);
        check({tag, " miso_word"}, 32'(got & mask), 32'(exp_word & mask));
        if (nbits > 16) check({tag, " miso_tail"}, 32'(extra), 32'd0);
        check({tag, " cmd_vld_cycles"}, cnt_vld, valid ? 1 : 0);
        check({tag, " frm_err_cycles"}, cnt_err, valid ? 0 : 1);
        if (valid) check({tag, " vld_latency"}, lat_vld, 4);
        else       check({tag, " err_latency"}, lat_err, 4);
        check({tag, " cmd_ch"}, 32'(cmd_ch), 32'(m_ch));
    endtask

    initial begin
        int nb;
        int kind;
        logic [2:0] ch;
        logic [2:0] cyc [4];
        cyc[0] = 3'd0; cyc[1] = 3'd4; cyc[2] = 3'd5; cyc[3] = 3'd6;

        // Reset state
        wait_clks(3);
        check("rst MISO", 32'(MISO), 32'd0);
        check("rst cmd_vld", 32'(cmd_vld), 32'd0);
        check("rst frm_err", 32'(frm_err), 32'd0);
        check("rst cmd_ch", 32'(cmd_ch), 32'd0);
        rst_n = 1'b1;
        wait_clks(3);

        // ch0 command: first frame returns zero, next returns lft_ld
        lft_ld = 12'hABC;
        run_frame("ch0_first", cmd_word(3'd0), 16, 4, 6, 1'b0);
        run_frame("ch0_resp", cmd_word(3'd0), 16, 4, 6, 1'b0);

        // ch6 value is captured at SS_n rise, not at the response frame
        batt = 12'h7FF;
        run_frame("ch6_cmd", cmd_word(3'd6), 16, 4, 6, 1'b0);
        batt = 12'h123;
        run_frame("ch2_cmd", cmd_word(3'd2), 16, 4, 6, 1'b0);
        steer_pot = 12'hFFF;
        run_frame("ch5_cmd", cmd_word(3'd5), 16, 4, 6, 1'b0);
        run_frame("ch0_after5", cmd_word(3'd0), 16, 4, 6, 1'b0);

        // Framing errors leave the previous result intact
        run_frame("short12", cmd_word(3'd4), 12, 4, 6, 1'b0);
        run_frame("bad_hdr", 16'hC000 | cmd_word(3'd4), 16, 4, 6, 1'b0);
        run_frame("long17", cmd_word(3'd4), 17, 4, 6, 1'b0);
        run_frame("after_err", cmd_word(3'd4), 16, 4, 6, 1'b0);

        // Last SCLK rise coincident with SS_n rise is counted first
        rght_ld = 12'h5A5;
        run_frame("joint_end", cmd_word(3'd4), 16, 4, 6, 1'b1);
        run_frame("joint_resp", cmd_word(3'd1), 16, 4, 6, 1'b0);

        // Reset partway through a frame
        lft_ld = 12'h321;
        run_frame("pre_rst", cmd_word(3'd0), 16, 4, 6, 1'b0);
        @(negedge clk);
        SS_n = 1'b0;
        wait_clks(5);
        for (int i = 0; i < 7; i++) begin
            SCLK = 1'b1; wait_clks(4);
            SCLK = 1'b0; wait_clks(4);
        end
        rst_n = 1'b0;
        #1;
        check("midrst MISO", 32'(MISO), 32'd0);
        check("midrst cmd_ch", 32'(cmd_ch), 32'd0);
        check("midrst state", 32'(dut.state == IDLE), 32'd1);
        m_resp = 12'h000;
        m_ch   = 3'd0;
        wait_clks(2);
        SS_n = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(3);
        run_frame("post_rst", cmd_word(3'd5), 16, 4, 6, 1'b0);

        // Back-to-back frames at the minimum phase length, cycling channels
        for (int r = 0; r < 12; r++) begin
            randomize_inputs();
            run_frame("min_cycle", cmd_word(cyc[r % 4]), 16, 4, 4, 1'b0);
        end

        // Randomized mix of good commands, arbitrary words and bad lengths
        for (int r = 0; r < 40; r++) begin
            randomize_inputs();
            kind = $urandom_range(0, 9);
            ch   = 3'($urandom_range(0, 7));
            if (kind <= 5) begin
                run_frame("rnd_cmd", cmd_word(ch), 16, 4, 7, 1'b0);
            end else if (kind <= 7) begin
                run_frame("rnd_word", 16'($urandom), 16, 4, 7, 1'b0);
            end else begin
                nb = $urandom_range(1, 20);
                if (nb == 16) nb = 15;
                run_frame("rnd_len", cmd_word(ch), nb, 4, 7, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
